// File: rtl/cv32e40p_x_commit_queue.sv
// XIF coprocessor front end: queues accepted offloads in issue order, releases
// committed entries one at a time to a single execution unit, returns results in order.
module cv32e40p_x_commit_queue #(
  parameter int          DEPTH  = 4,
  parameter int          ID_W   = 4,
  parameter logic [6:0]  OPCODE = 7'h2B
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_issue_valid_i,
  output logic            x_issue_ready_o,
  input  logic [31:0]     x_issue_instr_i,
  input  logic [ID_W-1:0] x_issue_id_i,
  input  logic [31:0]     x_issue_rs1_i,
  input  logic [31:0]     x_issue_rs2_i,
  output logic            x_issue_accept_o,
  output logic            x_issue_writeback_o,
  input  logic            x_commit_valid_i,
  input  logic [ID_W-1:0] x_commit_id_i,
  input  logic            x_commit_kill_i,
  output logic            exe_valid_o,
  input  logic            exe_ready_i,
  output logic [31:0]     exe_instr_o,
  output logic [31:0]     exe_rs1_o,
  output logic [31:0]     exe_rs2_o,
  input  logic            exe_done_i,
  input  logic [31:0]     exe_data_i,
  output logic            x_result_valid_o,
  input  logic            x_result_ready_i,
  output logic [ID_W-1:0] x_result_id_o,
  output logic [4:0]      x_result_rd_o,
  output logic [31:0]     x_result_data_o,
  output logic            x_result_we_o,
  output logic            err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {E_PEND, E_COMMIT, E_KILL} ent_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} fsm_e;

  logic [31:0]     q_instr [DEPTH];
  logic [31:0]     q_rs1   [DEPTH];
  logic [31:0]     q_rs2   [DEPTH];
  logic [ID_W-1:0] q_id    [DEPTH];
  ent_e            q_st    [DEPTH];

  logic [PW-1:0]   head, cmt, tail;
  logic [AW-1:0]   h_idx, c_idx, t_idx;
  logic            full, empty, push, pop, cmt_ok, exe_hs;
  fsm_e            fsm, fsm_nxt;
  logic [ID_W-1:0] cur_id;
  logic [4:0]      cur_rd;
  logic [31:0]     res_data;
  logic            res_we;

  assign h_idx = head[AW-1:0];
  assign c_idx = cmt[AW-1:0];
  assign t_idx = tail[AW-1:0];
  assign full  = (tail - head) == PW'(DEPTH);
  assign empty = head == tail;

  assign x_issue_ready_o     = !full;
  assign x_issue_accept_o    = x_issue_valid_i && !full && (x_issue_instr_i[6:0] == OPCODE);
  assign x_issue_writeback_o = x_issue_accept_o && (x_issue_instr_i[11:7] != 5'd0);
  assign push                = x_issue_accept_o;

  // cmt==tail blocks a commit for an id issued in the same cycle
  assign cmt_ok = x_commit_valid_i && (cmt != tail) && (q_id[c_idx] == x_commit_id_i);

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr[t_idx] <= x_issue_instr_i;
      q_rs1[t_idx]   <= x_issue_rs1_i;
      q_rs2[t_idx]   <= x_issue_rs2_i;
      q_id[t_idx]    <= x_issue_id_i;
      q_st[t_idx]    <= E_PEND;
    end
    if (cmt_ok) q_st[c_idx] <= x_commit_kill_i ? E_KILL : E_COMMIT;
  end

  always_comb begin
    fsm_nxt     = fsm;
    pop         = 1'b0;
    exe_valid_o = 1'b0;
    case (fsm)
      IDLE: if (!empty) begin
        if (q_st[h_idx] == E_KILL) pop = 1'b1;
        else if (q_st[h_idx] == E_COMMIT) begin
          exe_valid_o = 1'b1;
          if (exe_ready_i) begin
            pop     = 1'b1;
            fsm_nxt = EXEC;
          end
        end
      end
      EXEC:    if (exe_done_i) fsm_nxt = RESP;
      RESP:    if (x_result_ready_i) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  assign exe_hs      = exe_valid_o && exe_ready_i;
  assign exe_instr_o = exe_valid_o ? q_instr[h_idx] : 32'd0;
  assign exe_rs1_o   = exe_valid_o ? q_rs1[h_idx]   : 32'd0;
  assign exe_rs2_o   = exe_valid_o ? q_rs2[h_idx]   : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head     <= '0;
      cmt      <= '0;
      tail     <= '0;
      err_o    <= 1'b0;
      cur_id   <= '0;
      cur_rd   <= '0;
      res_data <= '0;
      res_we   <= 1'b0;
      x_result_id_o <= '0;
      x_result_rd_o <= '0;
    end else begin
      tail <= tail + PW'(push);
      cmt  <= cmt + PW'(cmt_ok);
      head <= head + PW'(pop);
      if (x_commit_valid_i && !cmt_ok) err_o <= 1'b1;
      // the entry is popped at the handshake, so keep what the result needs
      if (exe_hs) begin
        cur_id <= q_id[h_idx];
        cur_rd <= q_instr[h_idx][11:7];
      end
      if (fsm == EXEC && exe_done_i) begin
        res_data      <= exe_data_i;
        res_we        <= cur_rd != 5'd0;
        x_result_id_o <= cur_id;
        x_result_rd_o <= cur_rd;
      end
    end
  end

  assign x_result_valid_o = fsm == RESP;
  assign x_result_data_o  = res_data;
  assign x_result_we_o    = res_we && (fsm == RESP);
endmodule

// File: tb/tb_cv32e40p_x_commit_queue.sv
// Directed bench for cv32e40p_x_commit_queue: issue-decode table plus ordered sequences.
module tb_cv32e40p_x_commit_queue;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        x_issue_valid_i = 0, x_commit_valid_i = 0, x_commit_kill_i = 0;
  logic [31:0] x_issue_instr_i = 0, x_issue_rs1_i = 0, x_issue_rs2_i = 0, exe_data_i = 0;
  logic [3:0]  x_issue_id_i = 0, x_commit_id_i = 0;
  logic        exe_ready_i = 0, exe_done_i = 0, x_result_ready_i = 0;
  logic        x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o, exe_valid_o;
  logic [31:0] exe_instr_o, exe_rs1_o, exe_rs2_o, x_result_data_o;
  logic        x_result_valid_o, x_result_we_o, err_o;
  logic [3:0]  x_result_id_o;
  logic [4:0]  x_result_rd_o;
  int checks = 0, errors = 0;

  cv32e40p_x_commit_queue #(.DEPTH(4), .ID_W(4), .OPCODE(7'h2B)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
    .x_issue_instr_i(x_issue_instr_i), .x_issue_id_i(x_issue_id_i),
    .x_issue_rs1_i(x_issue_rs1_i), .x_issue_rs2_i(x_issue_rs2_i),
    .x_issue_accept_o(x_issue_accept_o), .x_issue_writeback_o(x_issue_writeback_o),
    .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
    .x_commit_kill_i(x_commit_kill_i),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i), .exe_instr_o(exe_instr_o),
    .exe_rs1_o(exe_rs1_o), .exe_rs2_o(exe_rs2_o), .exe_done_i(exe_done_i),
    .exe_data_i(exe_data_i),
    .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
    .x_result_id_o(x_result_id_o), .x_result_rd_o(x_result_rd_o),
    .x_result_data_o(x_result_data_o), .x_result_we_o(x_result_we_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        acc;
    logic        wb;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // inputs change 1 time unit after the edge; checks happen 1 unit later
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1; step(); step(); rst_i = 0; #1;
  endtask

  task automatic issue(logic [31:0] instr, logic [3:0] id, logic [31:0] rs1, logic [31:0] rs2);
    x_issue_valid_i = 1; x_issue_instr_i = instr; x_issue_id_i = id;
    x_issue_rs1_i = rs1; x_issue_rs2_i = rs2;
    step();
    x_issue_valid_i = 0;
  endtask

  task automatic commit(logic [3:0] id, logic kill);
    x_commit_valid_i = 1; x_commit_id_i = id; x_commit_kill_i = kill;
    step();
    x_commit_valid_i = 0; x_commit_kill_i = 0;
  endtask

  task automatic wait_exe(string nm);
    int n = 0;
    #1;
    while (!exe_valid_o && n < 20) begin step(); #1; n++; end
    if (!exe_valid_o) begin
      checks++; errors++;
      $display("FAIL %s exe_valid timeout act=0 exp=1", nm);
    end
  endtask

  // one exe handshake + done + result handshake; expects in-order id/rd/data
  task automatic run_exe(string nm, logic [3:0] id, logic [4:0] rd, logic [31:0] data);
    wait_exe(nm);
    chk({nm, "_exe_rd"}, {27'd0, exe_instr_o[11:7]}, {27'd0, rd});
    exe_ready_i = 1; step(); exe_ready_i = 0;
    exe_done_i = 1; exe_data_i = data; step(); exe_done_i = 0; #1;
    chk({nm, "_rvalid"}, {31'd0, x_result_valid_o}, 32'd1);
    chk({nm, "_rid"}, {28'd0, x_result_id_o}, {28'd0, id});
    chk({nm, "_rdata"}, x_result_data_o, data);
    x_result_ready_i = 1; step(); x_result_ready_i = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0020_82AB, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_002B, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_01B3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0020_82AB, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_052A, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FFAB, 1'b1, 1'b1};

    do_reset();
    chk("rst_ready", {31'd0, x_issue_ready_o}, 32'd1);
    chk("rst_exe_valid", {31'd0, exe_valid_o}, 32'd0);
    chk("rst_res_valid", {31'd0, x_result_valid_o}, 32'd0);
    chk("rst_we", {31'd0, x_result_we_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_res_data", x_result_data_o, 32'd0);

    // decode table: valid dropped before the edge so nothing is pushed
    for (int i = 0; i < 6; i++) begin
      x_issue_valid_i = vecs[i].valid; x_issue_instr_i = vecs[i].instr; #1;
      chk($sformatf("vec%0d_accept", i), {31'd0, x_issue_accept_o}, {31'd0, vecs[i].acc});
      chk($sformatf("vec%0d_wb", i), {31'd0, x_issue_writeback_o}, {31'd0, vecs[i].wb});
      x_issue_valid_i = 0; step();
    end

    // 1: single instruction end to end
    x_issue_valid_i = 1; x_issue_instr_i = 32'h0020_82AB; #1;
    chk("t1_accept", {31'd0, x_issue_accept_o}, 32'd1);
    chk("t1_wb", {31'd0, x_issue_writeback_o}, 32'd1);
    issue(32'h0020_82AB, 4'd3, 32'd5, 32'd7); #1;
    chk("t1_pend_no_exe", {31'd0, exe_valid_o}, 32'd0);
    commit(4'd3, 1'b0); #1;
    chk("t1_exe_valid", {31'd0, exe_valid_o}, 32'd1);
    chk("t1_exe_instr", exe_instr_o, 32'h0020_82AB);
    chk("t1_exe_rs1", exe_rs1_o, 32'd5);
    chk("t1_exe_rs2", exe_rs2_o, 32'd7);
    exe_ready_i = 1; step(); exe_ready_i = 0;
    exe_done_i = 1; exe_data_i = 32'd12; step(); exe_done_i = 0; #1;
    chk("t1_rvalid", {31'd0, x_result_valid_o}, 32'd1);
    chk("t1_rid", {28'd0, x_result_id_o}, 32'd3);
    chk("t1_rd", {27'd0, x_result_rd_o}, 32'd5);
    chk("t1_rdata", x_result_data_o, 32'd12);
    chk("t1_we", {31'd0, x_result_we_o}, 32'd1);
    x_result_ready_i = 1; step(); x_result_ready_i = 0; #1;
    chk("t1_rvalid_low", {31'd0, x_result_valid_o}, 32'd0);

    // 2: foreign opcode pushes nothing
    issue(32'h0000_01B3, 4'd9, 32'd1, 32'd2); step(); #1;
    chk("t2_no_exe", {31'd0, exe_valid_o}, 32'd0);
    chk("t2_ready", {31'd0, x_issue_ready_o}, 32'd1);
    chk("t2_err", {31'd0, err_o}, 32'd0);

    // 3: fill, mixed commit/kill, in-order results
    for (int i = 0; i < 4; i++) issue(32'h0000_002B | ((i + 1) << 7), 4'(i), 32'(i), 32'd0);
    #1;
    chk("t3_full_ready", {31'd0, x_issue_ready_o}, 32'd0);
    x_issue_valid_i = 1; x_issue_instr_i = 32'h0000_00AB; #1;
    chk("t3_full_accept", {31'd0, x_issue_accept_o}, 32'd0);
    x_issue_valid_i = 0;
    commit(4'd0, 1'b0); commit(4'd1, 1'b1); commit(4'd2, 1'b0); commit(4'd3, 1'b0);
    wait_exe("t3a");
    exe_ready_i = 1; step(); exe_ready_i = 0; #1;
    chk("t3_ready_after_pop", {31'd0, x_issue_ready_o}, 32'd1);
    exe_done_i = 1; exe_data_i = 32'hA0; step(); exe_done_i = 0; #1;
    chk("t3_r0_id", {28'd0, x_result_id_o}, 32'd0);
    chk("t3_r0_data", x_result_data_o, 32'hA0);
    x_result_ready_i = 1; step(); x_result_ready_i = 0;
    run_exe("t3_id2", 4'd2, 5'd3, 32'hA2);
    run_exe("t3_id3", 4'd3, 5'd4, 32'hA3);
    chk("t3_err", {31'd0, err_o}, 32'd0);

    // 4: out-of-order commit flags error, queue intact
    issue(32'h0000_02AB, 4'd4, 32'd0, 32'd0);
    issue(32'h0000_02AB, 4'd5, 32'd0, 32'd0);
    commit(4'd5, 1'b0); #1;
    chk("t4_err", {31'd0, err_o}, 32'd1);
    chk("t4_no_exe", {31'd0, exe_valid_o}, 32'd0);
    commit(4'd4, 1'b0);
    run_exe("t4_id4", 4'd4, 5'd5, 32'h44);
    commit(4'd5, 1'b0);
    run_exe("t4_id5", 4'd5, 5'd5, 32'h55);
    chk("t4_err_sticky", {31'd0, err_o}, 32'd1);
    do_reset();
    commit(4'd0, 1'b0); #1;
    chk("t4_empty_err", {31'd0, err_o}, 32'd1);
    do_reset();

    // 5: result back-pressure holds fields and blocks the next release
    issue(32'h0000_03AB, 4'd6, 32'd0, 32'd0);
    issue(32'h0000_01AB, 4'd7, 32'd0, 32'd0);
    commit(4'd6, 1'b0); commit(4'd7, 1'b0);
    wait_exe("t5");
    exe_ready_i = 1; step(); exe_ready_i = 0;
    exe_done_i = 1; exe_data_i = 32'hBEEF; step(); exe_done_i = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_hold_valid", {31'd0, x_result_valid_o}, 32'd1);
      chk("t5_hold_data", x_result_data_o, 32'hBEEF);
      chk("t5_hold_rd", {27'd0, x_result_rd_o}, 32'd7);
      chk("t5_no_exe", {31'd0, exe_valid_o}, 32'd0);
      step();
    end
    #1;
    chk("t5_rid", {28'd0, x_result_id_o}, 32'd6);
    x_result_ready_i = 1; step(); x_result_ready_i = 0; #1;
    chk("t5_next_exe", {31'd0, exe_valid_o}, 32'd1);
    chk("t5_next_rd", {27'd0, exe_instr_o[11:7]}, 32'd3);
    do_reset();

    // 6: reset in EXEC with 3 entries queued
    for (int i = 0; i < 4; i++) issue(32'h0000_00AB, 4'(i + 8), 32'd0, 32'd0);
    commit(4'd8, 1'b0);
    commit(4'd0, 1'b0);
    wait_exe("t6");
    exe_ready_i = 1; step(); exe_ready_i = 0;
    rst_i = 1; step(); rst_i = 0; #1;
    chk("t6_ready", {31'd0, x_issue_ready_o}, 32'd1);
    chk("t6_rvalid", {31'd0, x_result_valid_o}, 32'd0);
    chk("t6_err", {31'd0, err_o}, 32'd0);
    chk("t6_exe_valid", {31'd0, exe_valid_o}, 32'd0);
    exe_done_i = 1; exe_data_i = 32'h1; step(); exe_done_i = 0; #1;
    chk("t6_no_result", {31'd0, x_result_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
